alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares the single 16-bit CPU ALU between two requesters: req0 (pipeline EX stage) and req1 (debug/self-test port).
//  Arbitrates, registers operands into the ALU, captures result/flags after one EXEC cycle, returns a tagged response pulse.
//  Owns the architectural Z/V/N flag register; only the FLAG_OWNER requester's operations update it.
// PARAMETERS
//  FIXED_PRIO  0  0 = round-robin between req0/req1; 1 = req0 always wins
//  FLAG_OWNER  0  requester index whose ops may write the flag register
// PORTS
//  clk          in   1   system clock, all state on rising edge
//  rst_n        in   1   asynchronous active-low reset
//  reqN_valid   in   1   (N=0,1) request present; hold stable until accepted
//  reqN_ready   out  1   (N=0,1) grant; transfer when valid & ready same cycle
//  reqN_opcode  in   4   (N=0,1) ALU opcode 0x0..0xB valid
//  reqN_a       in   16  (N=0,1) operand 1
//  reqN_b       in   16  (N=0,1) operand 2
//  alu_in1      out  16  registered operand 1 to ALU
//  alu_in2      out  16  registered operand 2 to ALU
//  alu_opcode   out  4   registered opcode to ALU
//  alu_out      in   16  ALU result (combinational from alu_* outputs)
//  alu_z/v/n    in   1   ALU Z_set/V_set/N_set
//  rsp_valid    out  1   one-cycle response pulse
//  rsp_id       out  1   requester index of response
//  rsp_data     out  16  captured ALU result
//  rsp_err      out  1   opcode was 0xC..0xF
//  flags        out  3   {Z,V,N} architectural flag register
//  busy         out  1   high in EXEC
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0, flags=3'b000, rr pointer=req0, alu_* regs=0.
//  FSM: IDLE -> EXEC on accept; EXEC -> RESP always; RESP -> EXEC on accept, else IDLE.
//  Accept allowed only in IDLE or RESP; at most one reqN_ready high per cycle; ready is combinational.
//  Arbitration: one valid -> grant it; both valid -> FIXED_PRIO?req0 : requester != last granted.
//  Round-robin pointer updates only on accept; idle cycles do not move it.
//  Accept cycle: opcode/a/b/id latched into alu_* regs and id reg.
//  EXEC: ALU sees stable regs; alu_out/z/v/n sampled at end of EXEC.
//  RESP: rsp_valid=1 with rsp_id/rsp_data/rsp_err; response is not back-pressured.
//  Latency: accept at cycle T -> rsp_valid at T+2; max throughput 1 op / 2 cycles.
//  Flag writes (same edge as rsp capture), only if id==FLAG_OWNER and !err:
//   ADD/SUB (0x0,0x1): Z,V,N all written; XOR/SLL/SRA/ROR (0x2,0x4-0x6): Z only.
//   RED, PADDSB, LW/SW, LLB/LHB: flags unchanged.
//  Invalid opcode 0xC-0xF: accepted, rsp_data=0, rsp_err=1, no flag write.
//  rsp_* outputs hold last value outside RESP; only rsp_valid qualifies them.
//  Reset asserted mid-operation: in-flight op discarded, no rsp, flags cleared.
//  Request dropped (valid deasserted) before grant: no effect, pointer unchanged.
// TESTING
//  T1 req0 ADD a=0x7000 b=0x2000 at T -> T+2 rsp id0 data=0x7FFF; flags Z0 V1 N0.
//  T2 both valid, RR, 4 ops each -> grants alternate 0,1,0,1...; FIXED_PRIO=1 -> all req0 first.
//  T3 req1 SUB 5-5 -> rsp id1 data=0, flags unchanged from prior value 3'b010.
//  T4 req0 XOR 0x00FF^0x00FF after ADD set V -> flags Z1, V/N retained.
//  T5 req0 opcode 0xE -> rsp_err=1, data=0x0000, flags unchanged; next op accepted in RESP.
//  T6 rst_n low during EXEC -> no rsp_valid, flags=0, state IDLE, ready restored after release.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Shares one 16-bit CPU ALU between two requesters (req0: pipeline EX stage,
// req1: debug/self-test port). A granted request is registered into the ALU
// operand registers, the ALU result and flags are captured after one EXEC
// cycle, and a tagged one-cycle response is returned. The block also owns the
// architectural {Z,V,N} flag register; only the FLAG_OWNER requester's
// operations may update it.
//
// Timeline for a request accepted in cycle T:
//   T   : IDLE or RESP, reqN_ready high, operands latched at the closing edge
//   T+1 : EXEC, ALU sees stable operand registers, result captured at the edge
//   T+2 : RESP, rsp_valid high; a new request may be accepted in this cycle
module alu_share_arbiter #(
  parameter int unsigned FIXED_PRIO = 0,  // 0 = round-robin, 1 = req0 always wins
  parameter int unsigned FLAG_OWNER = 0   // requester index allowed to write flags
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_opcode,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_opcode,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,

  output logic [15:0] alu_in1,
  output logic [15:0] alu_in2,
  output logic [3:0]  alu_opcode,
  input  logic [15:0] alu_out,
  input  logic        alu_z,
  input  logic        alu_v,
  input  logic        alu_n,

  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic [2:0]  flags,
  output logic        busy
);

  // ALU opcode map (only the ones that touch the flag register matter here)
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_XOR = 4'h2;
  localparam logic [3:0] OP_SLL = 4'h4;
  localparam logic [3:0] OP_SRA = 4'h5;
  localparam logic [3:0] OP_ROR = 4'h6;

  localparam logic FIXED_MODE = (FIXED_PRIO != 0);
  localparam logic OWNER_ID   = FLAG_OWNER[0];

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e      r_state;
  state_e      w_state_nxt;

  // Requester that wins the next tie; reset points at req0.
  logic        r_rr_ptr;
  // Requester index of the operation currently in flight.
  logic        r_id;

  logic [15:0] r_alu_in1;
  logic [15:0] r_alu_in2;
  logic [3:0]  r_alu_opcode;

  logic        r_rsp_id;
  logic [15:0] r_rsp_data;
  logic        r_rsp_err;
  logic [2:0]  r_flags;

  logic        w_can_accept;
  logic        w_grant0;
  logic        w_grant1;
  logic        w_accept;
  logic        w_sel_id;
  logic [3:0]  w_sel_opcode;
  logic [15:0] w_sel_a;
  logic [15:0] w_sel_b;

  logic        w_op_err;
  logic        w_op_zvn;
  logic        w_op_z_only;
  logic        w_flag_en;

  // A new operation may start only when the ALU is free (IDLE) or its result
  // is being handed back this cycle (RESP).
  assign w_can_accept = (r_state == S_IDLE) || (r_state == S_RESP);

  // Arbitration: single requester wins outright; on a tie the fixed-priority
  // mode favours req0, otherwise the round-robin pointer decides.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (w_can_accept) begin
      if (req0_valid && req1_valid) begin
        if (FIXED_MODE || (r_rr_ptr == 1'b0)) begin
          w_grant0 = 1'b1;
        end else begin
          w_grant1 = 1'b1;
        end
      end else if (req0_valid) begin
        w_grant0 = 1'b1;
      end else if (req1_valid) begin
        w_grant1 = 1'b1;
      end
    end
  end

  assign w_accept   = w_grant0 | w_grant1;
  assign w_sel_id   = w_grant1;
  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;

  // Operand mux feeding the ALU input registers.
  always_comb begin
    w_sel_opcode = req0_opcode;
    w_sel_a      = req0_a;
    w_sel_b      = req0_b;
    if (w_sel_id) begin
      w_sel_opcode = req1_opcode;
      w_sel_a      = req1_a;
      w_sel_b      = req1_b;
    end
  end

  // Next-state logic: EXEC always lasts one cycle, RESP chains straight into
  // another EXEC when a request is accepted alongside the response.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = w_accept ? S_EXEC : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Round-robin pointer: moves only on an accept, pointing away from the
  // requester just served. Idle cycles and dropped requests leave it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= 1'b0;
    end else if (w_accept) begin
      r_rr_ptr <= ~w_sel_id;
    end
  end

  // Operand capture on accept; the registers stay stable through EXEC so the
  // combinational ALU has a full cycle to settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_in1    <= 16'h0000;
      r_alu_in2    <= 16'h0000;
      r_alu_opcode <= 4'h0;
      r_id         <= 1'b0;
    end else if (w_accept) begin
      r_alu_in1    <= w_sel_a;
      r_alu_in2    <= w_sel_b;
      r_alu_opcode <= w_sel_opcode;
      r_id         <= w_sel_id;
    end
  end

  // Opcode classification of the operation in flight.
  assign w_op_err    = (r_alu_opcode[3:2] == 2'b11);
  assign w_op_zvn    = (r_alu_opcode == OP_ADD) || (r_alu_opcode == OP_SUB);
  assign w_op_z_only = (r_alu_opcode == OP_XOR) || (r_alu_opcode == OP_SLL) ||
                       (r_alu_opcode == OP_SRA) || (r_alu_opcode == OP_ROR);
  assign w_flag_en   = (r_state == S_EXEC) && (r_id == OWNER_ID) && !w_op_err;

  // Response capture at the end of EXEC. The fields hold their value until
  // the next capture; rsp_valid alone says when they are meaningful.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_id   <= 1'b0;
      r_rsp_data <= 16'h0000;
      r_rsp_err  <= 1'b0;
    end else if (r_state == S_EXEC) begin
      r_rsp_id   <= r_id;
      r_rsp_data <= w_op_err ? 16'h0000 : alu_out;
      r_rsp_err  <= w_op_err;
    end
  end

  // Architectural flag register, written on the same edge as the response
  // capture. Arithmetic ops update all three flags, logical/shift ops only Z;
  // everything else (RED, PADDSB, memory, byte loads, invalid) leaves them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= 3'b000;
    end else if (w_flag_en) begin
      if (w_op_zvn) begin
        r_flags <= {alu_z, alu_v, alu_n};
      end else if (w_op_z_only) begin
        r_flags[2] <= alu_z;
      end
    end
  end

  assign alu_in1    = r_alu_in1;
  assign alu_in2    = r_alu_in2;
  assign alu_opcode = r_alu_opcode;

  assign rsp_valid  = (r_state == S_RESP);
  assign rsp_id     = r_rsp_id;
  assign rsp_data   = r_rsp_data;
  assign rsp_err    = r_rsp_err;
  assign flags      = r_flags;
  assign busy       = (r_state == S_EXEC);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
// Drives both requester ports, provides a behavioural ALU, and checks the
// arbiter against a transaction-level reference model. Accepted requests push
// their expected response into a scoreboard queue; an independent monitor
// pops and compares whenever the DUT presents a response.
module tb_alu_share_arbiter;

  localparam int FIXED_PRIO = 0;
  localparam int FLAG_OWNER = 0;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_opcode, req1_opcode;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [15:0] alu_in1, alu_in2, alu_out;
  logic [3:0]  alu_opcode;
  logic        alu_z, alu_v, alu_n;
  logic        rsp_valid, rsp_id, rsp_err, busy;
  logic [15:0] rsp_data;
  logic [2:0]  flags;

  alu_share_arbiter #(
    .FIXED_PRIO(FIXED_PRIO),
    .FLAG_OWNER(FLAG_OWNER)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_opcode(alu_opcode),
    .alu_out(alu_out), .alu_z(alu_z), .alu_v(alu_v), .alu_n(alu_n),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .flags(flags), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index: stable between edges, read by stimulus and monitor.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural 16-bit CPU ALU: returns {result, Z, V, N}. Invalid opcodes
  // produce junk so that the arbiter's zeroing of rsp_data is observable.
  function automatic logic [18:0] alu_ref(logic [3:0] op, logic [15:0] a, logic [15:0] b);
    logic [15:0] r;
    logic [15:0] s;
    logic        v;
    v = ^a[3:0];
    s = 16'h0000;
    case (op)
      4'h0: begin
        s = a + b;
        v = (a[15] == b[15]) && (s[15] != a[15]);
        r = v ? (a[15] ? 16'h8000 : 16'h7FFF) : s;
      end
      4'h1: begin
        s = a - b;
        v = (a[15] != b[15]) && (s[15] != a[15]);
        r = v ? (a[15] ? 16'h8000 : 16'h7FFF) : s;
      end
      4'h2: r = a ^ b;
      4'h3: r = {8'h00, a[15:8]} + {8'h00, a[7:0]} + {8'h00, b[15:8]} + {8'h00, b[7:0]};
      4'h4: r = a << b[3:0];
      4'h5: r = $signed(a) >>> b[3:0];
      4'h6: r = (a >> b[3:0]) | (a << (5'd16 - {1'b0, b[3:0]}));
      4'h7: r = a + b;
      4'h8, 4'h9: r = a + (b << 1);
      4'hA: r = {a[15:8], b[7:0]};
      4'hB: r = {b[7:0], a[7:0]};
      default: r = a ^ 16'hDEAD;
    endcase
    return {r, (r == 16'h0000), v, r[15]};
  endfunction

  assign {alu_out, alu_z, alu_v, alu_n} = alu_ref(alu_opcode, alu_in1, alu_in2);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic        id;
    logic [15:0] data;
    logic        err;
    logic [2:0]  flags;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   glog[$];

  // Reference-model state
  logic [2:0] m_flags;
  logic       m_inflight;
  int         m_tacc;
  int         m_last;  // last granted requester

  // Pending request per port (held until accepted or dropped)
  logic        pv  [2];
  logic [3:0]  pop [2];
  logic [15:0] pa  [2];
  logic [15:0] pb  [2];
  logic [1:0]  acc_last;

  logic [15:0] last_data;
  logic        last_id;

  task automatic model_reset();
    sb.delete();
    m_flags    = 3'b000;
    m_inflight = 1'b0;
    m_tacc     = 0;
    m_last     = 1;
  endtask

  task automatic load(int p, logic [3:0] op, logic [15:0] a, logic [15:0] b);
    pv[p] = 1'b1; pop[p] = op; pa[p] = a; pb[p] = b;
  endtask

  task automatic load_rand(int p);
    logic [15:0] a;
    a = 16'($urandom);
    load(p, 4'($urandom_range(15)), a, ($urandom_range(3) == 0) ? a : 16'($urandom));
  endtask

  // Expected response of an accepted request, from the spec's rules.
  task automatic model_accept(int p);
    logic [18:0] r;
    exp_t        e;
    r     = alu_ref(pop[p], pa[p], pb[p]);
    e.id  = (p == 1);
    e.err = (pop[p] >= 4'hC);
    e.data = e.err ? 16'h0000 : r[18:3];
    if (p == FLAG_OWNER && !e.err) begin
      if (pop[p] <= 4'h1) m_flags = r[2:0];
      else if (pop[p] == 4'h2 || (pop[p] >= 4'h4 && pop[p] <= 4'h6)) m_flags[2] = r[2];
    end
    e.flags = m_flags;
    e.due   = cyc + 2;
    sb.push_back(e);
    m_inflight = 1'b1;
    m_tacc     = cyc;
    m_last     = p;
    glog.push_back(p);
  endtask

  // One clock cycle of stimulus: drive, predict the grant, observe transfers.
  task automatic step();
    logic [1:0] exp_g;
    logic       allowed;
    @(negedge clk);
    req0_valid = pv[0]; req0_opcode = pop[0]; req0_a = pa[0]; req0_b = pb[0];
    req1_valid = pv[1]; req1_opcode = pop[1]; req1_a = pa[1]; req1_b = pb[1];
    #1;
    allowed = !m_inflight || (cyc >= m_tacc + 2);
    exp_g = 2'b00;
    if (allowed) begin
      if (pv[0] && pv[1]) exp_g = (FIXED_PRIO != 0 || m_last == 1) ? 2'b01 : 2'b10;
      else                exp_g = {pv[1], pv[0]};
    end
    check("ready", 32'({req1_ready, req0_ready}), 32'(exp_g));
    acc_last = {req1_valid & req1_ready, req0_valid & req0_ready};
    if (acc_last[0]) begin
      model_accept(0); pv[0] = 1'b0;
    end else if (acc_last[1]) begin
      model_accept(1); pv[1] = 1'b0;
    end
  endtask

  task automatic wait_accept(int p, string name);
    for (int i = 0; i < 10 && pv[p]; i++) step();
    check(name, 32'(pv[p]), 32'(0));
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && sb.size() > 0; i++) step();
    check("drain", 32'(sb.size()), 32'(0));
  endtask

  // Monitor: compares each presented response with the scoreboard head and
  // flags missing responses and unexpected busy.
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (rst_n) begin
      check("busy", 32'(busy), 32'(sb.size() > 0 && cyc == sb[0].due - 1));
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp", 32'(rsp_valid), 32'(0));
        end else begin
          e = sb.pop_front();
          check("rsp_time",  32'(cyc),      32'(e.due));
          check("rsp_id",    32'(rsp_id),   32'(e.id));
          check("rsp_data",  32'(rsp_data), 32'(e.data));
          check("rsp_err",   32'(rsp_err),  32'(e.err));
          check("rsp_flags", 32'(flags),    32'(e.flags));
          last_data = rsp_data;
          last_id   = rsp_id;
        end
      end else if (sb.size() > 0 && cyc >= sb[0].due) begin
        check("rsp_missing", 32'(rsp_valid), 32'(1));
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_first;
    int loads [2];
    for (int p = 0; p < 2; p++) begin
      pv[p] = 1'b0; pop[p] = 4'h0; pa[p] = 16'h0; pb[p] = 16'h0;
    end
    model_reset();
    acc_last  = 2'b00;
    last_data = 16'h0;
    last_id   = 1'b0;
    req0_valid = 1'b0; req0_opcode = 4'h0; req0_a = 16'h0; req0_b = 16'h0;
    req1_valid = 1'b0; req1_opcode = 4'h0; req1_a = 16'h0; req1_b = 16'h0;
    rst_n = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_alu_in1",   32'(alu_in1),    32'(0));
    check("rst_alu_in2",   32'(alu_in2),    32'(0));
    check("rst_alu_op",    32'(alu_opcode), 32'(0));
    check("rst_rsp_valid", 32'(rsp_valid),  32'(0));
    check("rst_rsp_data",  32'(rsp_data),   32'(0));
    check("rst_busy",      32'(busy),       32'(0));
    check("rst_flags",     32'(flags),      32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // T2: both requesters continuously valid -> grants alternate from req0
    glog.delete();
    load_rand(0); load_rand(1);
    loads[0] = 1; loads[1] = 1;
    for (int i = 0; i < 60 && (pv[0] || pv[1]); i++) begin
      step();
      for (int p = 0; p < 2; p++) begin
        if (acc_last[p] && loads[p] < 4) begin
          load_rand(p);
          loads[p]++;
        end
      end
    end
    drain();
    check("t2_grant_count", 32'(glog.size()), 32'(8));
    for (int i = 0; i < 8 && i < glog.size(); i++) check("t2_grant_order", 32'(glog[i]), 32'(i % 2));

    // T1: saturating ADD by the flag owner
    load(0, 4'h0, 16'h7000, 16'h2000);
    wait_accept(0, "t1_accept");
    drain();
    check("t1_data",  32'(last_data), 32'(16'h7FFF));
    check("t1_id",    32'(last_id),   32'(0));
    check("t1_flags", 32'(flags),     32'(3'b010));

    // T3: non-owner SUB leaves flags untouched
    load(1, 4'h1, 16'h0005, 16'h0005);
    wait_accept(1, "t3_accept");
    drain();
    check("t3_data",  32'(last_data), 32'(0));
    check("t3_id",    32'(last_id),   32'(1));
    check("t3_flags", 32'(flags),     32'(3'b010));

    // T4: owner XOR to zero sets Z, keeps V and N
    load(0, 4'h2, 16'h00FF, 16'h00FF);
    wait_accept(0, "t4_accept");
    drain();
    check("t4_flags", 32'(flags), 32'(3'b110));

    // T5: invalid opcode, then back-to-back accept during its RESP cycle
    load(0, 4'hE, 16'h1234, 16'h0001);
    wait_accept(0, "t5_accept_err");
    t_first = m_tacc;
    load(1, 4'h0, 16'h0003, 16'h0004);
    wait_accept(1, "t5_accept_next");
    check("t5_accept_in_resp", 32'(m_tacc - t_first), 32'(2));
    drain();
    check("t5_flags",     32'(flags),    32'(3'b110));
    check("t5_hold_data", 32'(rsp_data), 32'(16'h0007));
    check("t5_hold_id",   32'(rsp_id),   32'(1));

    // T6: reset during EXEC discards the operation and clears flags
    load(0, 4'h0, 16'h0001, 16'h0001);
    wait_accept(0, "t6_accept");
    @(negedge clk);
    #1;
    check("t6_busy_before_rst", 32'(busy), 32'(1));
    rst_n = 1'b0;
    pv[0] = 1'b0; pv[1] = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    model_reset();
    #1;
    check("t6_flags",     32'(flags),     32'(0));
    check("t6_rsp_valid", 32'(rsp_valid), 32'(0));
    check("t6_busy",      32'(busy),      32'(0));
    repeat (2) begin
      @(negedge clk);
      #1;
      check("t6_no_rsp_in_rst", 32'(rsp_valid), 32'(0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    load(1, 4'hA, 16'hAB00, 16'h00CD);
    step();
    check("t6_ready_after_rst", 32'(acc_last), 32'(2'b10));
    drain();
    check("t6_llb_data", 32'(last_data), 32'(16'hABCD));

    // Randomized traffic, including requests withdrawn before grant
    for (int i = 0; i < 600; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (pv[p] && $urandom_range(9) == 0) pv[p] = 1'b0;
        else if (!pv[p] && $urandom_range(1) == 1) load_rand(p);
      end
      step();
    end
    pv[0] = 1'b0; pv[1] = 1'b0;
    drain();
    check("final_flags", 32'(flags), 32'(m_flags));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
